alu_arbiter: RTL

- Shares the single combinational ALU (add, sub, and, or, not, unsigned set-less-than) between two requesters, e.g. the execute stage and an address/branch-compare unit.
- Accepts one operation at a time over a valid/ready handshake.
- Drives the ALU from registered operands, captures result and zero flag, and returns them on a per-requester response channel.
- Sits between the requesters and the ALU instance; the ALU itself stays outside this block.

---
 rtl/alu_pkg.sv | 19 +
 rtl/rr_arb2.sv | 30 +++
 rtl/alu_arbiter.sv | 138 +++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: op-code constants and FSM state encoding.
package alu_pkg;

    localparam int unsigned ALU_OPW = 3;

    localparam logic [ALU_OPW-1:0] ALU_ADD = 3'b000;
    localparam logic [ALU_OPW-1:0] ALU_SUB = 3'b001;
    localparam logic [ALU_OPW-1:0] ALU_AND = 3'b010;
    localparam logic [ALU_OPW-1:0] ALU_OR  = 3'b011;
    localparam logic [ALU_OPW-1:0] ALU_NOT = 3'b100;
    localparam logic [ALU_OPW-1:0] ALU_SLT = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-input grant: round-robin on ties when RR_EN is set, else requester 0 wins ties.
module rr_arb2 #(
    parameter bit RR_EN = 1'b1
) (
    input  logic valid0_i,
    input  logic valid1_i,
    input  logic last_grant_i,
    output logic gnt0_o,
    output logic gnt1_o,
    output logic gnt_idx_o
);

    always_comb begin
        gnt0_o = 1'b0;
        gnt1_o = 1'b0;
        if (valid0_i && valid1_i) begin
            // On a tie, hand the grant to whichever side did not win last time.
            if (RR_EN && !last_grant_i) begin
                gnt1_o = 1'b1;
            end else begin
                gnt0_o = 1'b1;
            end
        end else begin
            gnt0_o = valid0_i;
            gnt1_o = valid1_i;
        end
        gnt_idx_o = gnt1_o;
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between two requesters; one operation in
// flight, operands and results held in registers, response returned to the owner.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned OPW   = 3,
    parameter bit          RR_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_num1,
    input  logic [WIDTH-1:0] req0_num2,
    input  logic [OPW-1:0]   req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_num1,
    input  logic [WIDTH-1:0] req1_num2,
    input  logic [OPW-1:0]   req1_op,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_result,
    output logic             rsp0_zero,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_result,
    output logic             rsp1_zero,
    output logic [WIDTH-1:0] alu_num1,
    output logic [WIDTH-1:0] alu_num2,
    output logic [OPW-1:0]   alu_op,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    output logic             busy
);

    arb_state_e       state_q, state_d;
    logic [WIDTH-1:0] num1_q, num1_d;
    logic [WIDTH-1:0] num2_q, num2_d;
    logic [OPW-1:0]   op_q, op_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             owner_q, owner_d;
    logic             last_q, last_d;

    logic gnt0, gnt1, gnt_idx;
    logic in_idle;
    logic owner_rsp_ready;

    rr_arb2 #(
        .RR_EN(RR_EN)
    ) u_arb (
        .valid0_i    (req0_valid),
        .valid1_i    (req1_valid),
        .last_grant_i(last_q),
        .gnt0_o      (gnt0),
        .gnt1_o      (gnt1),
        .gnt_idx_o   (gnt_idx)
    );

    assign in_idle         = (state_q == IDLE);
    assign owner_rsp_ready = owner_q ? rsp1_ready : rsp0_ready;

    // Ready is forced low while reset is asserted, even though state already reads IDLE.
    assign req0_ready = in_idle & gnt0 & ~rst;
    assign req1_ready = in_idle & gnt1 & ~rst;

    always_comb begin
        state_d  = state_q;
        num1_d   = num1_q;
        num2_d   = num2_q;
        op_d     = op_q;
        result_d = result_q;
        zero_d   = zero_q;
        owner_d  = owner_q;
        last_d   = last_q;
        unique case (state_q)
            IDLE: begin
                if (gnt0 || gnt1) begin
                    num1_d  = gnt_idx ? req1_num1 : req0_num1;
                    num2_d  = gnt_idx ? req1_num2 : req0_num2;
                    op_d    = gnt_idx ? req1_op   : req0_op;
                    owner_d = gnt_idx;
                    last_d  = gnt_idx;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                result_d = alu_result;
                zero_d   = alu_zero;
                state_d  = RESP;
            end
            RESP: begin
                if (owner_rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            num1_q   <= '0;
            num2_q   <= '0;
            op_q     <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            num1_q   <= num1_d;
            num2_q   <= num2_d;
            op_q     <= op_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
        end
    end

    assign alu_num1 = num1_q;
    assign alu_num2 = num2_q;
    assign alu_op   = op_q;

    // Both channels always carry the captured result; only valid is steered to the owner.
    assign rsp0_valid  = (state_q == RESP) & ~owner_q;
    assign rsp1_valid  = (state_q == RESP) &  owner_q;
    assign rsp0_result = result_q;
    assign rsp1_result = result_q;
    assign rsp0_zero   = zero_q;
    assign rsp1_zero   = zero_q;
    assign busy        = ~in_idle;

endmodule
